// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: op codes, FSM states
// and instruction field placement.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_3   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_e;

  localparam int OP_W    = 2;
  localparam int RS2_LSB = 0;

  // Instruction layout is {op, rd, rs1, rs2}, each register field aw bits wide.
  function automatic int rs1_lsb(input int aw);
    return aw;
  endfunction

  function automatic int rd_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int op_lsb(input int aw);
    return 3 * aw;
  endfunction

  function automatic int instr_w(input int aw);
    return OP_W + 3 * aw;
  endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Instruction issue handshake between an upstream source and the issue stage.
interface alu_issue_wb_if #(
  parameter int INSTR_W = 8
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;

  modport master (
    output in_valid,
    output in_instr,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    output in_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// Register file: two async source reads, one async debug read, and a write
// port combining writeback and direct load (writeback wins on the same address).
module alu_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [AW-1:0]     rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  logic [DATA_W-1:0] regs [NREGS];

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dbg_data = regs[dbg_addr];

  // A load to a different register than the writeback still lands this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && wb_addr == AW'(i))
          regs[i] <= wb_data;
        else if (ld_en && ld_addr == AW'(i))
          regs[i] <= ld_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_wb.sv
// Operand-issue and writeback stage around an external combinational ALU.
// state | meaning
// IDLE  | ready for an instruction; operands snapshotted on accept
// EXEC  | operands held on alu_a/alu_b/alu_sel for ALU_LAT cycles
// WB    | alu_out written to rd, flags updated, wb_done high
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 4,
  parameter  int ALU_LAT = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_wb_if.slave     issue,
  input  logic              ld_valid,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_done,
  output logic              flag_z,
  output logic              flag_n,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int OP_LSB  = op_lsb(AW);
  localparam int RD_LSB  = rd_lsb(AW);
  localparam int RS1_LSB = rs1_lsb(AW);

  state_e            state;
  logic              ready_q;
  logic [1:0]        cnt;
  logic [AW-1:0]     rd_q;
  logic [OP_W-1:0]   op;
  logic [AW-1:0]     rd;
  logic [AW-1:0]     rs1;
  logic [AW-1:0]     rs2;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  assign op  = issue.in_instr[OP_LSB  +: OP_W];
  assign rd  = issue.in_instr[RD_LSB  +: AW];
  assign rs1 = issue.in_instr[RS1_LSB +: AW];
  assign rs2 = issue.in_instr[RS2_LSB +: AW];

  assign issue.in_ready = ready_q;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wb_en    (wb_done),
    .wb_addr  (rd_q),
    .wb_data  (alu_out),
    .ld_en    (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  // wb_done is high exactly while in WB, so it doubles as the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      cnt     <= '0;
      rd_q    <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= 2'b00;
      wb_done <= 1'b0;
      flag_z  <= 1'b1;
      flag_n  <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue.in_valid) begin
            alu_a   <= rs1_data;
            alu_b   <= rs2_data;
            alu_sel <= op;
            rd_q    <= rd;
            cnt     <= 2'(ALU_LAT - 1);
            ready_q <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            wb_done <= 1'b1;
            state   <= WB;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        WB: begin
          flag_z  <= (alu_out == '0);
          flag_n  <= alu_out[DATA_W-1];
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural register/flag/timing model compared
// every cycle, plus directed instruction sequences with literal expectations.
`timescale 1ns/1ps
module tb_alu_issue_wb;
  import alu_pkg::*;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_valid = 1'b0;
  logic [1:0] ld_addr = 2'd0;
  logic [7:0] ld_data = 8'd0;
  logic [7:0] alu_a, alu_b, alu_out, dbg_data;
  logic [1:0] alu_sel;
  logic [1:0] dbg_addr = 2'd0;
  logic       wb_done, flag_z, flag_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_wb_if #(.INSTR_W(8)) bus ();

  alu_issue_wb #(.DATA_W(8), .NREGS(4), .ALU_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .issue    (bus.slave),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .wb_done  (wb_done),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  function automatic logic [7:0] alu_fn(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_sel, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cycle-indexed; an accept in cycle N is busy through N+1+LAT, with writeback in that cycle.
  logic [7:0] m_reg [4] = '{default: 8'h00};
  logic [7:0] nr    [4];
  logic       m_z = 1'b1, m_n = 1'b0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_res = 8'h00;
  logic [1:0] m_sel = 2'b00, m_rd = 2'b00;
  int         cyc = 0;
  int         acc_c = -100;
  int         wb_c = -100;

  function automatic logic m_ready(input int c);
    return !(c > acc_c && c <= wb_c);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_reg = '{default: 8'h00};
      m_z = 1'b1; m_n = 1'b0;
      m_a = 8'h00; m_b = 8'h00; m_sel = 2'b00;
      acc_c = -100; wb_c = -100;
    end else begin
      nr = m_reg;
      if (m_ready(cyc) && bus.in_valid) begin
        m_sel = bus.in_instr[7:6];
        m_rd  = bus.in_instr[5:4];
        m_a   = m_reg[bus.in_instr[3:2]];
        m_b   = m_reg[bus.in_instr[1:0]];
        m_res = alu_fn(m_sel, m_a, m_b);
        acc_c = cyc;
        wb_c  = cyc + 1 + LAT;
      end
      if (ld_valid && !(cyc == wb_c && ld_addr == m_rd)) nr[ld_addr] = ld_data;
      if (cyc == wb_c) begin
        nr[m_rd] = m_res;
        m_z = (m_res == 8'h00);
        m_n = m_res[7];
      end
      m_reg = nr;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cyc >= 2) begin
      chk("in_ready", bus.in_ready, m_ready(cyc));
      chk("wb_done", wb_done, (cyc == wb_c));
      chk("flag_z", flag_z, m_z);
      chk("flag_n", flag_n, m_n);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_sel", alu_sel, m_sel);
      for (int i = 0; i < 4; i++) begin
        dbg_addr = 2'(i);
        #1;
        chk("dbg_reg", dbg_data, m_reg[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic issue(input logic [7:0] instr, output int acc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      if (bus.in_ready === 1'b1) begin
        acc = cyc;
        tick();
        break;
      end
      tick();
    end
    if (acc < 0) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_wb(output int c);
    c = -1;
    for (int k = 0; k < 10; k++) begin
      if (wb_done === 1'b1) begin
        c = cyc;
        break;
      end
      tick();
    end
    if (c < 0) chk("wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic pin_reg(input string name, input int a, input logic [7:0] e);
    chk(name, m_reg[a], e);
  endtask

  int acc, acc2, wbc;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_flag_z", flag_z, 1);
    chk("rst_flag_n", flag_n, 0);
    chk("rst_wb_done", wb_done, 0);
    chk("rst_alu_a", alu_a, 0);
    tick();

    // ADD R2,R0,R1 with 5+3
    load(2'd0, 8'h05);
    load(2'd1, 8'h03);
    issue(8'h21, acc);
    bus.in_valid = 1'b0;
    chk("exec_alu_a", alu_a, 8'h05);
    chk("exec_alu_b", alu_b, 8'h03);
    wait_wb(wbc);
    chk("wb_latency", 32'(wbc - acc), 32'd2);
    tick();
    pin_reg("r2_add", 2, 8'h08);
    chk("add_flag_z", flag_z, 0);
    chk("add_flag_n", flag_n, 0);

    // wrap to zero, then negative result
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    issue(8'h31, acc);
    bus.in_valid = 1'b0;
    wait_wb(wbc);
    tick();
    pin_reg("r3_wrap", 3, 8'h00);
    chk("wrap_flag_z", flag_z, 1);
    issue(8'h30, acc);
    bus.in_valid = 1'b0;
    wait_wb(wbc);
    tick();
    pin_reg("r3_neg", 3, 8'hFE);
    chk("neg_flag_n", flag_n, 1);
    chk("neg_flag_z", flag_z, 0);

    // back to back with in_valid held: ADD R1,R0,R0 then ADD R2,R1,R1
    issue(8'h10, acc);
    issue(8'h25, acc2);
    bus.in_valid = 1'b0;
    chk("b2b_accept_gap", 32'(acc2 - acc), 32'd2 + LAT);
    wait_wb(wbc);
    tick();
    pin_reg("b2b_r1", 1, 8'hFE);
    pin_reg("b2b_r2", 2, 8'hFC);

    // SUB R2,R0,R1; load R1 during EXEC, load R2 during WB
    issue(8'h61, acc);
    bus.in_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 8'h77;
    tick();
    chk("wb_cycle_done", wb_done, 1);
    chk("held_alu_b", alu_b, 8'hFE);
    ld_addr = 2'd2; ld_data = 8'hAA;
    tick();
    ld_valid = 1'b0;
    pin_reg("wb_wins_r2", 2, 8'h01);
    pin_reg("exec_load_r1", 1, 8'h77);

    // reset during EXEC aborts the instruction
    issue(8'hB1, acc);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", bus.in_ready, 1);
    chk("abort_wb_done", wb_done, 0);
    pin_reg("abort_r3", 3, 8'h00);
    tick();
    chk("abort_no_wb", wb_done, 0);

    // load to a source in the accept cycle: snapshot sees the pre-load value
    load(2'd0, 8'h80);
    ld_valid = 1'b1; ld_addr = 2'd0; ld_data = 8'h11;
    issue(8'hD2, acc);
    ld_valid = 1'b0;
    bus.in_valid = 1'b0;
    chk("snap_alu_a", alu_a, 8'h80);
    chk("snap_alu_sel", alu_sel, 2'b11);
    wait_wb(wbc);
    tick();
    pin_reg("xor_r1", 1, 8'h80);
    pin_reg("loaded_r0", 0, 8'h11);
    chk("xor_flag_n", flag_n, 1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
